// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared FSM state type and width constants for data_mem_resp.
package data_mem_pkg;
  localparam int CNT_W = 3;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: reset-less synchronous-write word array with a registered, clearable read port.
module dmem_array
  import data_mem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  // only the read register is cleared; storage keeps whatever was written
  always_ff @(posedge clk)
    r_rdata <= i_clr ? '0 : i_re ? r_mem[i_addr] : r_rdata;
  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: wait-state data memory responder (IDLE/WAIT/RESP FSM).
// Define DATA_MEM_OOR_ERR_EN to flag and suppress accesses with nonzero upper address bits.
module data_mem_resp
  import data_mem_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [15:0]       dAddr,
  input  logic [DATA_W-1:0] dOut,
  output logic [DATA_W-1:0] dIn,
  output logic              dRdy,
  output logic              dErr
);
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(WAIT_CYC == 0 ? 0 : WAIT_CYC - 1);
  state_t r_st, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic r_we, r_rdy, r_err;
  logic [15:0] r_addr;
  logic [DATA_W-1:0] r_wdata, w_wdata, w_rdata;
  logic [15:0] w_addr;
  logic w_idle, w_we, w_go, w_oor;
  always_comb begin
    w_nxt = r_st;
    w_cnt = r_cnt;
    case (r_st)
      IDLE: if (dReq) begin
        w_nxt = WAIT_CYC == 0 ? RESP : WAIT;
        w_cnt = LOAD;
      end
      WAIT: begin
        w_nxt = r_cnt == '0 ? RESP : WAIT;
        w_cnt = r_cnt == '0 ? '0 : r_cnt - CNT_W'(1);
      end
      default: w_nxt = IDLE;
    endcase
  end
  // with zero wait states the access commits at the accept edge, so use live inputs in IDLE
  assign w_idle  = r_st == IDLE;
  assign w_we    = w_idle ? dWe : r_we;
  assign w_addr  = w_idle ? dAddr : r_addr;
  assign w_wdata = w_idle ? dOut : r_wdata;
  assign w_go    = nreset && w_nxt == RESP;
`ifdef DATA_MEM_OOR_ERR_EN
  assign w_oor = |w_addr[15:ADDR_W];
`else
  logic w_unused;
  assign w_oor    = 1'b0;
  assign w_unused = ^w_addr[15:ADDR_W];
`endif
  always_ff @(posedge clk)
    if (!nreset) begin
      r_st  <= IDLE;
      r_cnt <= '0;
      r_rdy <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_st  <= w_nxt;
      r_cnt <= w_cnt;
      r_rdy <= w_go;
      r_err <= w_go && w_oor;
    end
  always_ff @(posedge clk)
    if (w_idle && dReq) begin
      r_we    <= dWe;
      r_addr  <= dAddr;
      r_wdata <= dOut;
    end
  dmem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk     (clk),
    .i_we    (w_go && w_we && !w_oor),
    .i_re    (w_go && !w_we && !w_oor),
    .i_clr   (!nreset || (w_go && !w_we && w_oor)),
    .i_addr  (w_addr[ADDR_W-1:0]),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );
  assign dIn  = w_rdata;
  assign dRdy = r_rdy;
  assign dErr = r_err;
endmodule
